irq_controller: RTL

Interrupt controller that consumes the per-source interrupt request lines produced by the peripherals (timers 0-3, display, DMA, keypad, serial, game pak) and drives the CPU interrupt line. Holds the IE, IF and IME registers, latches rising edges of each source into IF, and supports write-1-to-clear acknowledgement from the CPU. Sits between the peripheral tops (for example the timer IRQ outputs) and the core's IRQ input. It also provides a HALT wake-up line.

---
 rtl/gba_irq_pkg.sv | 26 ++
 rtl/irq_controller_if.sv | 27 ++
 rtl/irq_edge_latch.sv | 24 ++
 rtl/irq_controller.sv | 55 +++++
 4 files changed

// File: rtl/gba_irq_pkg.sv
// Shared interrupt definitions: source bit indices and IO register offsets for IE/IF/IME.
package gba_irq_pkg;

    localparam int unsigned NUM_IRQ_SRC = 14;

    localparam int unsigned IRQ_VBLANK  = 0;
    localparam int unsigned IRQ_HBLANK  = 1;
    localparam int unsigned IRQ_VCOUNT  = 2;
    localparam int unsigned IRQ_TIMER0  = 3;
    localparam int unsigned IRQ_TIMER1  = 4;
    localparam int unsigned IRQ_TIMER2  = 5;
    localparam int unsigned IRQ_TIMER3  = 6;
    localparam int unsigned IRQ_SERIAL  = 7;
    localparam int unsigned IRQ_DMA0    = 8;
    localparam int unsigned IRQ_DMA1    = 9;
    localparam int unsigned IRQ_DMA2    = 10;
    localparam int unsigned IRQ_DMA3    = 11;
    localparam int unsigned IRQ_KEYPAD  = 12;
    localparam int unsigned IRQ_GAMEPAK = 13;

    // Byte offsets within the IO register block.
    localparam logic [9:0] REG_IE  = 10'h200;
    localparam logic [9:0] REG_IF  = 10'h202;
    localparam logic [9:0] REG_IME = 10'h208;

endpackage

// File: rtl/irq_controller_if.sv
// Request/register-access bundle between peripherals, CPU and the interrupt controller.
interface irq_controller_if #(
    parameter int unsigned NUM_SRC = 14
);
    logic [NUM_SRC-1:0] irq_src;
    logic               ie_we;
    logic [15:0]        ie_wdata;
    logic               if_we;
    logic [15:0]        if_wdata;
    logic               ime_we;
    logic               ime_wdata;
    logic [15:0]        IE;
    logic [15:0]        IF;
    logic               IME;
    logic               irq;
    logic               halt_wake;

    modport master (
        output irq_src, ie_we, ie_wdata, if_we, if_wdata, ime_we, ime_wdata,
        input  IE, IF, IME, irq, halt_wake
    );

    modport slave (
        input  irq_src, ie_we, ie_wdata, if_we, if_wdata, ime_we, ime_wdata,
        output IE, IF, IME, irq, halt_wake
    );
endinterface

// File: rtl/irq_edge_latch.sv
// One interrupt flag: rising-edge detect on the request line, write-1-to-clear ack, set wins.
module irq_edge_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    input  logic ack,
    output logic flag
);
    logic src_prev;
    logic rise;

    assign rise = src & ~src_prev;

    // src_prev resets high so a line already asserted at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_prev <= 1'b1;
            flag     <= 1'b0;
        end else begin
            src_prev <= src;
            flag     <= (flag & ~ack) | rise;
        end
    end
endmodule

// File: rtl/irq_controller.sv
// IE/IF/IME register block driving the registered CPU IRQ and the HALT wake-up line.
module irq_controller
    import gba_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_IRQ_SRC
) (
    input logic        clock_16,
    input logic        reset_n,
    irq_controller_if.slave bus
);
    logic [NUM_SRC-1:0] ie_q;
    logic [NUM_SRC-1:0] if_q;
    logic [NUM_SRC-1:0] ack_mask;
    logic               ime_q;
    logic               irq_q;

    assign ack_mask = bus.if_we ? bus.if_wdata[NUM_SRC-1:0] : '0;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_flag
        irq_edge_latch u_latch (
            .clk   (clock_16),
            .rst_n (reset_n),
            .src   (bus.irq_src[i]),
            .ack   (ack_mask[i]),
            .flag  (if_q[i])
        );
    end

    always_ff @(posedge clock_16 or negedge reset_n) begin
        if (!reset_n) begin
            ie_q  <= '0;
            ime_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (bus.ie_we) begin
                ie_q <= bus.ie_wdata[NUM_SRC-1:0];
            end
            if (bus.ime_we) begin
                ime_q <= bus.ime_wdata;
            end
            irq_q <= ime_q & (|(ie_q & if_q));
        end
    end

    if (NUM_SRC < 16) begin : g_pad
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^{bus.ie_wdata[15:NUM_SRC], bus.if_wdata[15:NUM_SRC]};
    end

    assign bus.IE        = 16'(ie_q);
    assign bus.IF        = 16'(if_q);
    assign bus.IME       = ime_q;
    assign bus.irq       = irq_q;
    assign bus.halt_wake = |(ie_q & if_q);
endmodule
